// File: rtl/udm_uart_rx.sv
// udm_uart_rx: UART 8N1/8N2 receiver feeding bytes to the UDM protocol engine.
// Latency: byte appears on data_o/valid_o 1 cycle after the mid-stop sample (+1 with majority voting).
// Backpressure: one-byte holding register; a byte completing while it is full and not accepted is dropped (overrun_o).
//
// Ports:
//   clk_i, rst_ni        system clock, asynchronous active-low reset
//   rx_i                 raw serial line (idle high), synchronised internally
//   div_i, stop2_i       clocks-per-bit and stop-bit count, latched at start detection
//   data_o, valid_o      received byte, held until valid_o && ready_i
//   ready_i              consumer accept
//   frame_err_o          1-cycle pulse: a stop bit was sampled low
//   overrun_o            1-cycle pulse: a completed byte was dropped
//   busy_o               a frame is in progress
// Optional: define UDM_UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.

module udm_uart_rx #(
  parameter int unsigned DIV_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rx_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             stop2_i,
  output logic [7:0]       data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             frame_err_o,
  output logic             overrun_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev_q;

  state_t                 state_q, state_d;
  logic [DIV_W-1:0]       cnt_q, cnt_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [DIV_W-1:0]       div_clamped;
  logic [DIV_W-1:0]       reload;
  logic                   stop2_q, stop2_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shreg_q, shreg_d;
  logic                   stop_second_q, stop_second_d;

  logic                   samp_evt;
  logic                   bit_val;
  logic                   byte_done;
  logic                   ferr;

  logic [7:0]             data_q;
  logic                   valid_q;
  logic                   ferr_q;
  logic                   ovr_q;

  assign rx_s        = sync_q[SYNC_STAGES-1];
  assign div_clamped = (div_i < DIV_W'(4)) ? DIV_W'(4) : div_i;

`ifdef UDM_UART_RX_MAJORITY_EN
  // Samples at cnt==1 and cnt==0 are stored; the vote happens one cycle later
  // using the live rx_s as the third sample. The counter holds at 0 for that
  // cycle, so the reload is div_q-2 to keep the bit period at div_q.
  logic s1_q, s0_q, vote_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= 1'b1;
      s0_q   <= 1'b1;
      vote_q <= 1'b0;
    end else if (state_q != IDLE) begin
      if (cnt_q == DIV_W'(1))          s1_q <= rx_s;
      if (cnt_q == '0 && !vote_q)      s0_q <= rx_s;
      vote_q <= (cnt_q == '0) && !vote_q;
    end else begin
      vote_q <= 1'b0;
    end
  end

  assign samp_evt = vote_q;
  assign bit_val  = (s1_q & s0_q) | (s1_q & rx_s) | (s0_q & rx_s);
  assign reload   = div_q - DIV_W'(2);
`else
  assign samp_evt = (cnt_q == '0);
  assign bit_val  = rx_s;
  assign reload   = div_q - DIV_W'(1);
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    div_d         = div_q;
    stop2_d       = stop2_q;
    bit_idx_d     = bit_idx_q;
    shreg_d       = shreg_q;
    stop_second_d = stop_second_q;
    byte_done     = 1'b0;
    ferr          = 1'b0;

    if (cnt_q != '0) cnt_d = cnt_q - DIV_W'(1);

    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s) begin
          div_d   = div_clamped;
          stop2_d = stop2_i;
          cnt_d   = div_clamped >> 1;
          state_d = START;
        end
      end
      START: begin
        if (samp_evt) begin
          if (!bit_val) begin
            cnt_d     = reload;
            bit_idx_d = '0;
            state_d   = DATA;
          end else begin
            // Line back high at mid-start: a glitch, not a frame.
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (samp_evt) begin
          shreg_d   = {bit_val, shreg_q[7:1]};
          cnt_d     = reload;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            stop_second_d = 1'b0;
            state_d       = STOP;
          end
        end
      end
      STOP: begin
        if (samp_evt) begin
          if (!bit_val) begin
            ferr    = 1'b1;
            state_d = IDLE;
          end else if (stop2_q && !stop_second_q) begin
            stop_second_d = 1'b1;
            cnt_d         = reload;
          end else begin
            // Leave at mid-stop so the next start edge is not missed.
            byte_done = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q        <= '1;
      rx_prev_q     <= 1'b1;
      state_q       <= IDLE;
      cnt_q         <= '0;
      div_q         <= DIV_W'(4);
      stop2_q       <= 1'b0;
      bit_idx_q     <= '0;
      shreg_q       <= '0;
      stop_second_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rx_prev_q     <= rx_s;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_q         <= div_d;
      stop2_q       <= stop2_d;
      bit_idx_q     <= bit_idx_d;
      shreg_q       <= shreg_d;
      stop_second_q <= stop_second_d;
    end
  end

  // Output holding register. A byte completing in the same cycle as an
  // accept replaces the old one without an overrun.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= ferr;
      ovr_q  <= 1'b0;
      if (byte_done) begin
        if (valid_q && !ready_i) begin
          ovr_q <= 1'b1;
        end else begin
          data_q  <= shreg_q;
          valid_q <= 1'b1;
        end
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_udm_uart_rx.sv
// tb_udm_uart_rx: scoreboard bench for udm_uart_rx.
// Expected bytes are queued as frames are driven and popped on each accept.
// Frame-error, overrun and valid-cycle events are counted and checked per scenario.

module tb_udm_uart_rx;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        rx_i = 1'b1;
  logic [31:0] div_i = 32'd16;
  logic        stop2_i = 1'b0;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic        frame_err_o;
  logic        overrun_o;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int vld_cyc  = 0;

  int f0, o0, v0;

  udm_uart_rx dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rx_i        (rx_i),
    .div_i       (div_i),
    .stop2_i     (stop2_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor on the falling edge, away from the DUT's active edge.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (frame_err_o) ferr_cnt++;
      if (overrun_o)   ovr_cnt++;
      if (valid_o)     vld_cyc++;
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          chk("sb_pop_nonempty", exp_q.size(), 1);
        end else begin
          chk("sb_data", data_o, exp_q.pop_front());
        end
      end
    end
  end

  task automatic put_bit(input logic v, input int n);
    rx_i = v;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic s1, input logic s2,
                            input bit two, input int idle_bits);
    int d;
    d = int'(div_i);
    put_bit(1'b0, d);
    for (int i = 0; i < 8; i++) put_bit(b[i], d);
    put_bit(s1, d);
    if (two) put_bit(s2, d);
    rx_i = 1'b1;
    if (idle_bits > 0) put_bit(1'b1, idle_bits * d);
  endtask

  task automatic snap();
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    v0 = vld_cyc;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_data",  data_o, 8'h00);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_ferr",  frame_err_o, 1'b0);
    chk("rst_ovr",   overrun_o, 1'b0);
    chk("rst_busy",  busy_o, 1'b0);
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;

    // 0x55, one stop bit, consumer ready
    div_i = 32'd16; stop2_i = 1'b0; ready_i = 1'b1;
    snap();
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b1, 1'b0, 0);
    chk("t1_busy_after_stop", busy_o, 1'b0);
    put_bit(1'b1, 32);
    chk("t1_valid_cycles", vld_cyc - v0, 1);
    chk("t1_ferr", ferr_cnt - f0, 0);

    // Stop bit low on 0xA5, then a clean 0x3C
    snap();
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 2);
    chk("t2_ferr", ferr_cnt - f0, 1);
    chk("t2_no_valid", vld_cyc - v0, 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 2);
    chk("t2_valid_after", vld_cyc - v0, 1);
    chk("t2_ferr_after", ferr_cnt - f0, 1);

    // Short low glitch rejected at mid-start
    snap();
    put_bit(1'b0, 4);
    put_bit(1'b1, 40);
    chk("t3_busy", busy_o, 1'b0);
    chk("t3_valid", vld_cyc - v0, 0);
    chk("t3_ferr", ferr_cnt - f0, 0);

    // Back-to-back bytes with consumer stalled: second byte overruns
    ready_i = 1'b0;
    snap();
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 1'b1, 1'b0, 0);
    send_frame(8'h34, 1'b1, 1'b1, 1'b0, 1);
    chk("t4_ovr", ovr_cnt - o0, 1);
    chk("t4_valid_held", valid_o, 1'b1);
    chk("t4_data_held", data_o, 8'h12);
    chk("t4_ferr", ferr_cnt - f0, 0);
    ready_i = 1'b1;
    @(posedge clk_i);
    #1 ready_i = 1'b0;
    chk("t4_valid_clr", valid_o, 1'b0);
    chk("t4_data_kept", data_o, 8'h12);
    ready_i = 1'b1;

    // Two stop bits: second stop low, then both high
    div_i = 32'd868; stop2_i = 1'b1;
    snap();
    send_frame(8'hFE, 1'b1, 1'b0, 1'b1, 2);
    chk("t5_ferr_stop2", ferr_cnt - f0, 1);
    chk("t5_no_valid", vld_cyc - v0, 0);
    exp_q.push_back(8'hFE);
    send_frame(8'hFE, 1'b1, 1'b1, 1'b1, 0);
    chk("t5_busy_after_stop", busy_o, 1'b0);
    put_bit(1'b1, 2 * 868);
    chk("t5_valid", vld_cyc - v0, 1);
    chk("t5_data", data_o, 8'hFE);

    // Reset in the middle of the data bits of 0x77
    div_i = 32'd16; stop2_i = 1'b0;
    snap();
    put_bit(1'b0, 16);
    put_bit(1'b1, 16);
    put_bit(1'b1, 16);
    put_bit(1'b1, 8);
    chk("t6_busy_mid", busy_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_data", data_o, 8'h00);
    chk("t6_rst_valid", valid_o, 1'b0);
    chk("t6_rst_busy", busy_o, 1'b0);
    chk("t6_rst_ferr", frame_err_o, 1'b0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    put_bit(1'b1, 16 * 12);
    chk("t6_no_valid", vld_cyc - v0, 0);
    chk("t6_no_ferr", ferr_cnt - f0, 0);
    exp_q.push_back(8'h88);
    send_frame(8'h88, 1'b1, 1'b1, 1'b0, 2);
    chk("t6_data", data_o, 8'h88);

`ifdef UDM_UART_RX_MAJORITY_EN
    // One-cycle high glitch at the centre of bit 0 of 0x00
    snap();
    exp_q.push_back(8'h00);
    put_bit(1'b0, 16);
    put_bit(1'b0, 8);
    put_bit(1'b1, 1);
    put_bit(1'b0, 7);
    for (int i = 1; i < 8; i++) put_bit(1'b0, 16);
    put_bit(1'b1, 16);
    put_bit(1'b1, 32);
    chk("t7_valid", vld_cyc - v0, 1);
    chk("t7_data", data_o, 8'h00);
    chk("t7_ferr", ferr_cnt - f0, 0);
`endif

    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
